ram_port_arbiter: RTL

//  Synchronous front-end that shares one asynchronous SRAM chip (active-low CS/WE/OE,

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/ram_rr_arb2.sv | 28 ++
 rtl/ram_port_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared state encoding, strobe-counter width and STROBE_CYC range check
// for the SRAM port arbiter.
`ifndef RAM_CTRL_PKG_SV
`define RAM_CTRL_PKG_SV

`define RAM_CTRL_STROBE_CYC_OK(n) (((n) >= 1) && ((n) <= 15))

package ram_ctrl_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // Wide enough for the largest legal STROBE_CYC - 1.
  localparam int STROBE_CNT_W = 4;
endpackage

`endif

// File: rtl/ram_rr_arb2.sv
// Two-input round-robin grant; the pointer toggles once per completed access.
module ram_rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (advance) begin
      r_ptr <= ~r_ptr;
    end
  end

  // A lone requester always wins; on a tie the pointer holder wins.
  always_comb begin
    grant[0] = req[0] & (~req[1] | ~r_ptr);
    grant[1] = req[1] & (~req[0] |  r_ptr);
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one asynchronous SRAM between two requesters with round-robin grant
// and registered setup/strobe/hold sequencing of the chip strobes.
// state  | meaning
// IDLE   | waiting for a request; grant and latch on the next edge
// SETUP  | address (and write data) presented, strobes high
// STROBE | CS plus WE or OE low for STROBE_CYC cycles
// HOLD   | strobes high, done pulse, write data released on the next edge
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  input  logic              r1_valid,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic              ram_oe_n
);

  if (!`RAM_CTRL_STROBE_CYC_OK(STROBE_CYC)) begin : g_bad_strobe_cyc
    $error("ram_port_arbiter: STROBE_CYC must be within 1..15");
  end

  localparam logic [STROBE_CNT_W-1:0] CNT_LOAD = STROBE_CNT_W'(STROBE_CYC - 1);

  logic [1:0]              r_state;
  logic [STROBE_CNT_W-1:0] r_cnt;
  logic                    r_gnt1;
  logic                    r_we;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic                    r_drive;
  logic                    r_cs_n;
  logic                    r_we_n;
  logic                    r_oe_n;
  logic                    r_done0;
  logic                    r_done1;
  logic [DATA_W-1:0]       r_rdata;

  logic [1:0]              w_grant;
  logic                    w_advance;
  logic                    w_pick1;
  logic                    w_sel_we;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic [DATA_W-1:0]       w_sel_wdata;

  assign w_advance = (r_state == HOLD);

  ram_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({r1_valid, r0_valid}),
    .advance (w_advance),
    .grant   (w_grant)
  );

  assign w_pick1     = w_grant[1];
  assign w_sel_we    = w_pick1 ? r1_we    : r0_we;
  assign w_sel_addr  = w_pick1 ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_pick1 ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gnt1  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_drive <= 1'b0;
      r_cs_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_gnt1  <= w_pick1;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_drive <= w_sel_we;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_cs_n  <= 1'b0;
          r_we_n  <= ~r_we;
          r_oe_n  <= r_we;
          r_cnt   <= CNT_LOAD;
          r_state <= STROBE;
        end
        STROBE: begin
          if (r_cnt == '0) begin
            r_cs_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            // The chip is still driving here: OE rises with this same edge.
            if (!r_we) begin
              r_rdata <= ram_data;
            end
            r_done0 <= ~r_gnt1;
            r_done1 <= r_gnt1;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_drive <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ram_data = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign ram_addr = r_addr;
  assign ram_cs_n = r_cs_n;
  assign ram_we_n = r_we_n;
  assign ram_oe_n = r_oe_n;
  assign r0_done  = r_done0;
  assign r1_done  = r_done1;
  assign rdata    = r_rdata;

endmodule
